// File: rtl/snake_game_if.sv
`default_nettype none
// ============================================================================
// snake_game_if : keyboard/collision inputs and datapath controls of the sequencer
// Revision: 1.0
// ============================================================================
interface snake_game_if;
  logic [4:0]  number_input;
  logic [4:0]  direction;
  logic        pause_key;
  logic        good_collision;
  logic        bad_collision;
  logic        inmenu;
  logic        ingame;
  logic        initial_head;
  logic        allow_moving;
  logic        move_tick;
  logic        game_over;
  logic [3:0]  main_difficulty;
  logic [12:0] score;
  logic [2:0]  state;

  modport master (
    input  number_input, direction, pause_key, good_collision, bad_collision,
    output inmenu, ingame, initial_head, allow_moving, move_tick, game_over,
           main_difficulty, score, state
  );

  modport slave (
    output number_input, direction, pause_key, good_collision, bad_collision,
    input  inmenu, ingame, initial_head, allow_moving, move_tick, game_over,
           main_difficulty, score, state
  );
endinterface
`default_nettype wire

// File: rtl/snake_game_sequencer.sv
`default_nettype none
// ============================================================================
// snake_game_sequencer : menu/wait/play/pause/over sequencing, move ticks, score
// Revision: 1.0
// ============================================================================
module snake_game_sequencer #(
  parameter int TICK_BASE        = 840000,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  snake_game_if.master bus
);

  localparam int FRAME_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam int HOLD_W  = (OVER_HOLD_FRAMES > 0) ? $clog2(OVER_HOLD_FRAMES + 1) : 1;

  localparam logic [FRAME_W-1:0] c_FRAME_LAST = FRAME_W'(TICK_BASE - 1);
  localparam logic [HOLD_W-1:0]  c_HOLD_LAST  = HOLD_W'(OVER_HOLD_FRAMES - 1);
  localparam logic [12:0]        c_SCORE_MAX  = 13'h1FFF;

  typedef enum logic [2:0] {
    S_MENU   = 3'd0,
    S_WAIT   = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t             r_state;
  logic [3:0]         r_difficulty;
  logic [12:0]        r_score;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [3:0]         r_move_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_move_tick;

  logic       w_menu_go;
  logic [3:0] w_diff_sel;
  logic       w_dir_valid;
  logic       w_frame_pulse;
  logic       w_move_last;

  always_comb begin
    w_menu_go  = 1'b1;
    w_diff_sel = r_difficulty;
    case (bus.number_input)
      5'b00010: w_diff_sel = 4'd4;
      5'b00100: w_diff_sel = 4'd2;
      5'b01000: w_diff_sel = 4'd1;
      default:  w_menu_go  = 1'b0;
    endcase
  end

  always_comb begin
    w_dir_valid = 1'b0;
    case (bus.direction)
      5'b00010, 5'b00100, 5'b01000, 5'b10000: w_dir_valid = 1'b1;
      default:                                w_dir_valid = 1'b0;
    endcase
  end

  assign w_frame_pulse = (r_frame_cnt == c_FRAME_LAST);
  assign w_move_last   = (r_move_cnt == (r_difficulty - 4'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_MENU;
      r_difficulty <= 4'd1;
      r_score      <= '0;
      r_frame_cnt  <= '0;
      r_move_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_move_tick  <= 1'b0;
    end else begin
      r_move_tick <= 1'b0;
      case (r_state)
        S_MENU: begin
          if (w_menu_go) begin
            r_state      <= S_WAIT;
            r_difficulty <= w_diff_sel;
            r_score      <= '0;
            r_frame_cnt  <= '0;
            r_move_cnt   <= '0;
            r_hold_cnt   <= '0;
          end
        end
        S_WAIT: begin
          r_frame_cnt <= '0;
          r_move_cnt  <= '0;
          if (w_dir_valid) r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (w_frame_pulse) begin
            r_frame_cnt <= '0;
            if (w_move_last) begin
              r_move_cnt  <= '0;
              r_move_tick <= 1'b1;
            end else begin
              r_move_cnt <= r_move_cnt + 4'd1;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
          // Frame count restarts on entry to OVER so the hold time is a whole number of frames.
          if (bus.bad_collision) begin
            r_state     <= S_OVER;
            r_hold_cnt  <= '0;
            r_frame_cnt <= '0;
          end else begin
            if (bus.pause_key) r_state <= S_PAUSED;
            if (bus.good_collision && (r_score != c_SCORE_MAX)) r_score <= r_score + 13'd1;
          end
        end
        S_PAUSED: begin
          if (bus.pause_key) r_state <= S_PLAY;
        end
        S_OVER: begin
          if (w_frame_pulse) begin
            r_frame_cnt <= '0;
            if (r_hold_cnt == c_HOLD_LAST) begin
              r_state    <= S_MENU;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        default: r_state <= S_MENU;
      endcase
    end
  end

  assign bus.inmenu          = (r_state == S_MENU);
  assign bus.ingame          = (r_state != S_MENU);
  assign bus.initial_head    = (r_state == S_WAIT);
  assign bus.allow_moving    = (r_state == S_PLAY);
  assign bus.game_over       = (r_state == S_OVER);
  assign bus.move_tick       = r_move_tick;
  assign bus.main_difficulty = r_difficulty;
  assign bus.score           = r_score;
  assign bus.state           = r_state;

endmodule
`default_nettype wire
